// File: rtl/hazard_pkg.sv
// Shared types and decode helpers for the pipeline hazard control unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_TIMEOUT  = 2'd3
    } hcu_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Write-enables of every pipeline register plus the two flush controls.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_INIT     = 7'b00000_11;
    localparam pipe_ctrl_t CTRL_FREEZE   = 7'b00000_00;
    localparam pipe_ctrl_t CTRL_NORMAL   = 7'b11111_00;
    localparam pipe_ctrl_t CTRL_BRANCH   = 7'b11111_11;
    localparam pipe_ctrl_t CTRL_LOAD_USE = 7'b00111_01;

    // A load in EX whose destination feeds the instruction in ID; x0 never creates a hazard.
    function automatic logic is_load_use(input logic       mem_read,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Normal-flow decode; a taken branch outranks load-use since the dependent instruction is on the wrong path.
    function automatic pipe_ctrl_t run_decode(input logic branch, input logic load_use);
        pipe_ctrl_t ctrl;
        if (branch) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end else begin
            ctrl = CTRL_NORMAL;
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/hazard_control_unit_mem_wait_timer.sv
// Counts consecutive frozen memory cycles and flags the cycle on which the wait limit is hit.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic              TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] ONE_W      = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] MAX_W      = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] LAST_WAIT  = TIMEOUT_EN ? WAIT_W'(MEM_TIMEOUT - 1) : MAX_W;

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              timeout_s;

    // Timeout fires on the last tolerated frozen cycle while memory is still not ready.
    always_comb begin
        timeout_s = 1'b0;
        if (TIMEOUT_EN && active && !mem_ready && (wait_cnt_r == LAST_WAIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Wait counter: the stall-detect cycle counts as the first frozen cycle; release clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (start) begin
            wait_cnt_r <= ONE_W;
        end else if (active) begin
            if (mem_ready) begin
                wait_cnt_r <= '0;
            end else if (!timeout_s && (wait_cnt_r != MAX_W)) begin
                wait_cnt_r <= wait_cnt_r + ONE_W;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign timeout = timeout_s;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: memory-wait freeze, branch flush, load-use bubble,
// memory timeout with sticky error and saturating stall/flush counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_Rs1,
    input  logic [4:0]       if_id_Rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_MemRead,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hcu_state_t       state_r;
    hcu_state_t       state_nxt_s;
    pipe_ctrl_t       ctrl_s;
    logic             mem_stall_s;
    logic             load_use_s;
    logic             timer_start_s;
    logic             timeout_s;
    logic             stall_evt_s;
    logic             flush_evt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             err_r;

    assign mem_stall_s = mem_req && !mem_ready;
    assign load_use_s  = is_load_use(id_ex_MemRead, id_ex_rd, if_id_Rs1, if_id_Rs2);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .WAIT_W      (WAIT_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (timer_start_s),
        .active    (state_r == ST_MEM_WAIT),
        .mem_ready (mem_ready),
        .timeout   (timeout_s)
    );

    // Next-state and per-cycle pipeline control decode.
    always_comb begin
        state_nxt_s   = state_r;
        ctrl_s        = CTRL_FREEZE;
        timer_start_s = 1'b0;
        stall_evt_s   = 1'b0;
        flush_evt_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                ctrl_s      = CTRL_INIT;
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall_s) begin
                    ctrl_s        = CTRL_FREEZE;
                    timer_start_s = 1'b1;
                    stall_evt_s   = 1'b1;
                    state_nxt_s   = ST_MEM_WAIT;
                end else begin
                    ctrl_s      = run_decode(branch_taken, load_use_s);
                    stall_evt_s = !ctrl_s.pc_write;
                    flush_evt_s = branch_taken;
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl_s      = run_decode(branch_taken, load_use_s);
                    stall_evt_s = !ctrl_s.pc_write;
                    flush_evt_s = branch_taken;
                    state_nxt_s = ST_RUN;
                end else if (timeout_s) begin
                    ctrl_s      = CTRL_FREEZE;
                    stall_evt_s = 1'b1;
                    state_nxt_s = ST_TIMEOUT;
                end else begin
                    ctrl_s      = CTRL_FREEZE;
                    stall_evt_s = 1'b1;
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            ST_TIMEOUT: begin
                ctrl_s      = CTRL_FREEZE;
                state_nxt_s = ST_TIMEOUT;
            end
            default: begin
                ctrl_s      = CTRL_INIT;
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sticky timeout error; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Saturating stall counter; clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (cnt_clr) begin
            stall_cnt_r <= '0;
        end else if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating branch-flush counter; clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= '0;
        end else if (cnt_clr) begin
            flush_cnt_r <= '0;
        end else if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign pc_write        = ctrl_s.pc_write;
    assign if_id_write     = ctrl_s.if_id_write;
    assign id_ex_write     = ctrl_s.id_ex_write;
    assign ex_mem_write    = ctrl_s.ex_mem_write;
    assign mem_wb_write    = ctrl_s.mem_wb_write;
    assign if_id_flush     = ctrl_s.if_id_flush;
    assign id_ex_flush     = ctrl_s.id_ex_flush;
    assign stall_cnt       = stall_cnt_r;
    assign flush_cnt       = flush_cnt_r;
    assign mem_timeout_err = err_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed + randomized bench for hazard_control_unit against a cycle-level behavioural model.
module tb_hazard_control_unit;

    localparam int CNT_W       = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int WAIT_W      = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       if_id_Rs1 = 5'd0;
    logic [4:0]       if_id_Rs2 = 5'd0;
    logic [4:0]       id_ex_rd = 5'd0;
    logic             id_ex_MemRead = 1'b0;
    logic             branch_taken = 1'b0;
    logic             mem_req = 1'b0;
    logic             mem_ready = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic             if_id_flush, id_ex_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout_err;

    int checks = 0;
    int failures = 0;

    // Behavioural model: how the pipeline should look, not how the RTL is built.
    bit m_first;      // first cycle after reset release
    int m_frozen;     // consecutive stalled memory cycles so far (0 = not waiting)
    bit m_dead;       // memory timed out, block is parked
    int m_stall;
    int m_flush;
    bit m_err;

    hazard_control_unit #(
        .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .WAIT_W(WAIT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_Rs1(if_id_Rs1), .if_id_Rs2(if_id_Rs2), .id_ex_rd(id_ex_rd),
        .id_ex_MemRead(id_ex_MemRead), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout_err(mem_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_first  = 1'b1;
        m_frozen = 0;
        m_dead   = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
        m_err    = 1'b0;
    endtask

    // Entered just after a rising edge: pulse reset, check async clear, release after the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 16'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                             if_id_flush, id_ex_flush}), 16'h0003);
        chk("rst_stall", 16'(stall_cnt), 16'd0);
        chk("rst_flush", 16'(flush_cnt), 16'd0);
        chk("rst_err", 16'(mem_timeout_err), 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One cycle: apply inputs, check at the falling edge against the model, advance the model at the rising edge.
    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic br, input logic req,
                        input logic rdy, input logic clr);
        bit        lu, stalled, stall_ev, flush_ev;
        logic [6:0] exp;
        id_ex_MemRead = mr; id_ex_rd = rd; if_id_Rs1 = rs1; if_id_Rs2 = rs2;
        branch_taken = br; mem_req = req; mem_ready = rdy; cnt_clr = clr;
        lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        stalled = !m_first && !m_dead && !rdy && ((m_frozen > 0) || req);
        if (m_first)               exp = 7'b0000011;
        else if (m_dead || stalled) exp = 7'b0000000;
        else if (br)               exp = 7'b1111111;
        else if (lu)               exp = 7'b0011101;
        else                       exp = 7'b1111100;
        stall_ev = !m_first && !m_dead && !exp[6];
        flush_ev = !m_first && !m_dead && !stalled && br;
        @(negedge clk);
        chk("ctrl", 16'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                         if_id_flush, id_ex_flush}), 16'(exp));
        chk("stall_cnt", 16'(stall_cnt), 16'(m_stall));
        chk("flush_cnt", 16'(flush_cnt), 16'(m_flush));
        chk("err", 16'(mem_timeout_err), 16'(m_err));
        @(posedge clk);
        if (m_first) begin
            m_first = 1'b0;
        end else if (!m_dead) begin
            if (stalled) begin
                m_frozen++;
                if (MEM_TIMEOUT != 0 && m_frozen == MEM_TIMEOUT) begin
                    m_dead = 1'b1;
                    m_err  = 1'b1;
                end
            end else begin
                m_frozen = 0;
            end
        end
        m_stall = clr ? 0 : (stall_ev ? ((m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX) : m_stall);
        m_flush = clr ? 0 : (flush_ev ? ((m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX) : m_flush);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reset release: INIT cycle, then normal flow.
        idle(3);

        // Load-use on rs2, then the same with x0 as destination.
        step(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("lu_stall_one", 16'(stall_cnt), 16'd1);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("lu_x0_nostall", 16'(stall_cnt), 16'd1);

        // Branch together with load-use: branch wins.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("br_lu_flush", 16'(flush_cnt), 16'd1);
        chk("br_lu_stall", 16'(stall_cnt), 16'd0);

        // Three frozen cycles with a branch pending, released on the fourth.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("memwait_stall", 16'(stall_cnt), 16'd3);

        // Timeout: memory never ready, then ready arrives too late, then reset.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout_err", 16'(mem_timeout_err), 16'd1);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        idle(2);

        // Saturation at CNT_W=2, then clear together with a stall.
        for (int i = 0; i < 5; i++) step(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_sat", 16'(stall_cnt), 16'd3);
        step(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("clr_over_evt", 16'(stall_cnt), 16'd0);

        // Reset in the middle of a memory wait.
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        do_reset();
        idle(2);

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
